// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Single-outstanding RISC-V style load/store unit in front of a simple
// byte-addressed data memory.
//
// A request is accepted in IDLE, decoded and range-checked. A legal request is
// issued to memory for one cycle (ISSUE). A store then responds. A load waits
// one cycle (CAPTURE) for the memory data, then sign- or zero-extends it.
// An illegal request skips memory entirely and responds with resp_err=1.
//
// Optional build macro:
//   LSU_MISALIGN_TRAP_EN - when defined, misaligned half and word accesses are
//                          rejected with resp_err=1. When undefined, they are
//                          issued unchanged with byte-granular addressing.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = store, 0 = load
//   req_funct3        LB/LH/LW/LBU/LHU or SB/SH/SW encoding
//   req_addr          byte address
//   req_wdata         store data, low-aligned
//   resp_valid/ready  response handshake
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          request rejected, no memory access made
//   mem_*             data-memory strobes, address, write data, read data
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_half,
  output logic        mem_byte,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Memory size widened so the end-of-access comparison cannot overflow.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  // Request decode
  logic [1:0]  req_size;
  logic [2:0]  req_nbytes;
  logic [32:0] req_last_addr;
  logic        funct3_ok;
  logic        range_ok;
  logic        align_ok;
  logic        req_ok;
  logic        accept;
  logic [31:0] load_ext;

  assign req_size = req_funct3[1:0];

  always_comb begin
    req_nbytes = 3'd4;
    case (req_size)
      2'd0:    req_nbytes = 3'd1;
      2'd1:    req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
  end

  // Loads allow LB/LH/LW/LBU/LHU; stores allow only SB/SH/SW.
  always_comb begin
    if (req_we) begin
      funct3_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2);
    end else begin
      funct3_ok = (req_funct3 != 3'd3) && (req_funct3 != 3'd6) && (req_funct3 != 3'd7);
    end
  end

  assign req_last_addr = {1'b0, req_addr} + {30'd0, req_nbytes} - 33'd1;
  assign range_ok      = (req_last_addr < MEM_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    align_ok = 1'b1;
    if (req_size == 2'd1) begin
      align_ok = ~req_addr[0];
    end else if (req_size == 2'd2) begin
      align_ok = (req_addr[1:0] == 2'b00);
    end
  end
`else
  assign align_ok = 1'b1;
`endif

  assign req_ok = funct3_ok & range_ok & align_ok;
  assign accept = req_valid & (state_reg == IDLE);

  // Load data extension, driven by the registered funct3.
  always_comb begin
    load_ext = mem_rdata;
    case (funct3_reg)
      3'd0:    load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'd1:    load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd4:    load_ext = {24'd0, mem_rdata[7:0]};
      3'd5:    load_ext = {16'd0, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state and strobes
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_half   = 1'b0;
    mem_byte   = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = req_ok ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        mem_read   = ~we_reg;
        mem_write  = we_reg;
        mem_half   = (funct3_reg[1:0] == 2'd1);
        mem_byte   = (funct3_reg[1:0] == 2'd0);
        state_next = we_reg ? RESP : CAPTURE;
      end
      CAPTURE: begin
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request/response datapath. Address and write data only change on a legal
  // accept, so the memory bus holds its last values between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg         <= 1'b0;
      funct3_reg     <= 3'd0;
      mem_addr_reg   <= 32'd0;
      mem_wdata_reg  <= 32'd0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        resp_err_reg   <= ~req_ok;
        resp_rdata_reg <= 32'd0;
        if (req_ok) begin
          we_reg        <= req_we;
          funct3_reg    <= req_funct3;
          mem_addr_reg  <= req_addr;
          mem_wdata_reg <= req_wdata;
        end
      end
      if (state_reg == CAPTURE) begin
        resp_rdata_reg <= load_ext;
      end
    end
  end

  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit with a 256-byte behavioural memory.
// Memory is (re)initialised while rst is high:
//   mem[0..5] = FF 54 01 02 04 08, mem[255] = 80, all other bytes 0.
// Latency is counted in cycles after the accept cycle: resp_valid is expected
// in cycle 1 for errors, 2 for stores and 3 for loads.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic        mem_half;
  logic        mem_byte;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  logic [7:0] mem [0:255];

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_half   (mem_half),
    .mem_byte   (mem_byte),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: writes on the strobe edge, zero-extended read
  // data valid the cycle after the read strobe.
  always @(posedge clk) begin
    logic [7:0] a;
    a = mem_addr[7:0];
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0]   <= 8'hFF;
      mem[1]   <= 8'h54;
      mem[2]   <= 8'h01;
      mem[3]   <= 8'h02;
      mem[4]   <= 8'h04;
      mem[5]   <= 8'h08;
      mem[255] <= 8'h80;
      mem_rdata <= 32'd0;
    end else begin
      if (mem_write) begin
        mem[a] <= mem_wdata[7:0];
        if (!mem_byte) mem[a + 8'd1] <= mem_wdata[15:8];
        if (!mem_byte && !mem_half) begin
          mem[a + 8'd2] <= mem_wdata[23:16];
          mem[a + 8'd3] <= mem_wdata[31:24];
        end
      end
      if (mem_read) begin
        if (mem_byte)      mem_rdata <= {24'd0, mem[a]};
        else if (mem_half) mem_rdata <= {16'd0, mem[a + 8'd1], mem[a]};
        else               mem_rdata <= {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
      end
    end
    rd_cnt <= rd_cnt + (mem_read ? 1 : 0);
    wr_cnt <= wr_cnt + (mem_write ? 1 : 0);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request/response transaction; hold = cycles resp_ready stays low
  // after resp_valid is first seen.
  task automatic run_txn(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int lat;
    int exp_lat;
    int rd0;
    int wr0;
    exp_lat = exp_err ? 1 : (we ? 2 : 3);
    @(negedge clk);
    check_val({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1 && !exp_err) begin
        check_val({name, " mem_addr"}, mem_addr, addr);
        check_val({name, " strobes"}, {28'd0, mem_read, mem_write, mem_half, mem_byte},
                  {28'd0, ~we, we, f3[1:0] == 2'd1, f3[1:0] == 2'd0});
        if (we) check_val({name, " mem_wdata"}, mem_wdata, wdata);
      end
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      check_val({name, " timeout"}, 32'd0, 32'd1);
      return;
    end
    check_val({name, " latency"}, lat, exp_lat);
    check_val({name, " rdata"}, resp_rdata, exp_rdata);
    check_val({name, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_val({name, " hold valid"}, {31'd0, resp_valid}, 32'd1);
      check_val({name, " hold rdata"}, resp_rdata, exp_rdata);
      check_val({name, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check_val({name, " reads"}, rd_cnt - rd0, (!exp_err && !we) ? 1 : 0);
    check_val({name, " writes"}, wr_cnt - wr0, (!exp_err && we) ? 1 : 0);
    check_val({name, " back to idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
    $display("txn %-10s we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             name, we, f3, addr, wdata, resp_rdata, resp_err, lat);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset ready/valid/err", {29'd0, req_ready, resp_valid, resp_err}, 32'h4);
    check_val("reset rdata", resp_rdata, 32'd0);
    check_val("reset mem_addr", mem_addr, 32'd0);
    check_val("reset mem_wdata", mem_wdata, 32'd0);
    check_val("reset strobes", {28'd0, mem_read, mem_write, mem_half, mem_byte}, 32'd0);
    $display("txn reset      ready=%0d valid=%0d", req_ready, resp_valid);
    rst = 1'b0;

    run_txn("LW0",   1'b0, 3'd2, 32'd0,   32'd0, 32'h020154FF, 1'b0, 0);
    run_txn("LB0",   1'b0, 3'd0, 32'd0,   32'd0, 32'hFFFFFFFF, 1'b0, 0);
    run_txn("LBU0",  1'b0, 3'd4, 32'd0,   32'd0, 32'h000000FF, 1'b0, 0);
    run_txn("LH0",   1'b0, 3'd1, 32'd0,   32'd0, 32'h000054FF, 1'b0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    run_txn("LHU1",  1'b0, 3'd5, 32'd1,   32'd0, 32'h00000000, 1'b1, 0);
`else
    run_txn("LHU1",  1'b0, 3'd5, 32'd1,   32'd0, 32'h00000154, 1'b0, 0);
`endif
    run_txn("SW16",  1'b1, 3'd2, 32'd16,  32'hDEADBEEF, 32'd0, 1'b0, 0);
    run_txn("SB17",  1'b1, 3'd0, 32'd17,  32'h000000AA, 32'd0, 1'b0, 0);
    run_txn("LW16",  1'b0, 3'd2, 32'd16,  32'd0, 32'hDEADAAEF, 1'b0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    run_txn("LW2",   1'b0, 3'd2, 32'd2,   32'd0, 32'h00000000, 1'b1, 0);
`else
    run_txn("LW2",   1'b0, 3'd2, 32'd2,   32'd0, 32'h08040201, 1'b0, 0);
`endif
    run_txn("LW253", 1'b0, 3'd2, 32'd253, 32'd0, 32'h00000000, 1'b1, 0);
    run_txn("LB255", 1'b0, 3'd0, 32'd255, 32'd0, 32'hFFFFFF80, 1'b0, 0);
    run_txn("LD_F3", 1'b0, 3'd3, 32'd0,   32'd0, 32'h00000000, 1'b1, 0);
    run_txn("ST_F5", 1'b1, 3'd5, 32'd8,   32'h12345678, 32'd0, 1'b1, 0);
    run_txn("LH254", 1'b0, 3'd1, 32'd254, 32'd0, 32'hFFFF8000, 1'b0, 0);
    run_txn("LH255", 1'b0, 3'd1, 32'd255, 32'd0, 32'h00000000, 1'b1, 0);
    run_txn("LHUhld",1'b0, 3'd5, 32'd0,   32'd0, 32'h000054FF, 1'b0, 5);

    // Reset while the load is in CAPTURE.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'd4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);              // ISSUE
    @(negedge clk);              // CAPTURE
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("rst-capture ready/valid", {30'd0, req_ready, resp_valid}, 32'h2);
    check_val("rst-capture strobes", {28'd0, mem_read, mem_write, mem_half, mem_byte}, 32'd0);
    check_val("rst-capture mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rst-capture no resp", {31'd0, resp_valid}, 32'd0);
    $display("txn rst-capt   ready=%0d valid=%0d", req_ready, resp_valid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
